// File: rtl/fx2_slave_fifo_ctrl_if.sv
// Valid/ready word stream between the FX2 slave-FIFO controller and the core datapath.
// The master drives data/valid and the slave answers with ready.
interface fx2_slave_fifo_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fx2_slave_fifo_ctrl.sv
// FPGA-side master for the FX2 slave-FIFO bus: arbitrates the shared fd bus between reads from INEP
// and writes to OUTEP, and commits short packets with PKTEND after a write-idle timeout.
module fx2_slave_fifo_ctrl #(
    parameter int unsigned OUTEP          = 2,
    parameter int unsigned INEP           = 6,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned PKTEND_TIMEOUT = 64
) (
    input  logic                 ifclk,
    input  logic                 reset,
    inout  wire  [15:0]          fd,
    output logic                 SLWR,
    output logic                 SLRD,
    output logic                 SLOE,
    output logic                 PKTEND,
    output logic [1:0]           FIFOADDR,
    input  logic                 EMPTY_FLAG,
    input  logic                 FULL_FLAG,
    fx2_slave_fifo_ctrl_if.master from_host,
    fx2_slave_fifo_ctrl_if.slave  to_host
);
    localparam logic [1:0]  FA_OUT    = 2'(OUTEP / 2 - 1);
    localparam logic [1:0]  FA_IN     = 2'(INEP / 2 - 1);
    localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);
    localparam logic [15:0] IDLE_MAX  = 16'(PKTEND_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_SETUP,
        S_RD_STROBE,
        S_RD_HOLD1,
        S_RD_HOLD2,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_GAP,
        S_WR_REL,
        S_PKT
    } state_t;

    state_t      state;
    logic [7:0]  burst;
    logic        rr_wr;
    logic        fd_oe;
    logic [15:0] fd_q;
    logic        th_ready;

    logic [15:0] rbuf [2];
    logic        rb_wr;
    logic        rb_rd;
    logic [1:0]  rb_count;
    logic        rb_push;
    logic        rb_pop;
    logic        rb_free;

    logic [15:0] idle_cnt;
    logic        wrote;
    logic        pkt_due;
    logic        rd_ok;
    logic        wr_ok;

    assign fd            = fd_oe ? fd_q : 'z;
    assign to_host.ready = th_ready;

    assign rb_push         = (state == S_RD_STROBE);
    assign rb_pop          = from_host.valid && from_host.ready;
    assign rb_free         = (rb_count != 2'd2);
    assign from_host.data  = rbuf[rb_rd];
    assign from_host.valid = (rb_count != 2'd0);

    assign pkt_due = (idle_cnt == IDLE_MAX) && wrote;
    assign rd_ok   = EMPTY_FLAG && rb_free;
    assign wr_ok   = to_host.valid && FULL_FLAG;

    always_ff @(posedge ifclk) begin
        if (reset) begin
            rb_wr    <= 1'b0;
            rb_rd    <= 1'b0;
            rb_count <= '0;
        end else begin
            if (rb_push) begin
                rbuf[rb_wr] <= fd;
                rb_wr       <= ~rb_wr;
            end
            if (rb_pop)
                rb_rd <= ~rb_rd;
            case ({rb_push, rb_pop})
                2'b10:   rb_count <= rb_count + 2'd1;
                2'b01:   rb_count <= rb_count - 2'd1;
                default: rb_count <= rb_count;
            endcase
        end
    end

    // Write-idle timer for short-packet commit; wrote marks data sent since the last PKTEND.
    always_ff @(posedge ifclk) begin
        if (reset) begin
            idle_cnt <= '0;
            wrote    <= 1'b0;
        end else if (state == S_WR_STROBE) begin
            idle_cnt <= '0;
            wrote    <= 1'b1;
        end else begin
            if (idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + 16'd1;
            if (state == S_PKT)
                wrote <= 1'b0;
        end
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            state    <= S_IDLE;
            SLWR     <= 1'b1;
            SLRD     <= 1'b1;
            SLOE     <= 1'b1;
            PKTEND   <= 1'b1;
            FIFOADDR <= FA_IN;
            fd_oe    <= 1'b0;
            fd_q     <= '0;
            th_ready <= 1'b0;
            rr_wr    <= 1'b0;
            burst    <= '0;
        end else begin
            SLRD     <= 1'b1;
            SLWR     <= 1'b1;
            PKTEND   <= 1'b1;
            th_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_ok && (!wr_ok || !rr_wr)) begin
                        state    <= S_RD_SETUP;
                        FIFOADDR <= FA_IN;
                        SLOE     <= 1'b0;
                        burst    <= '0;
                        rr_wr    <= ~rr_wr;
                    end else if (wr_ok) begin
                        state    <= S_WR_SETUP;
                        FIFOADDR <= FA_OUT;
                        SLOE     <= 1'b1;
                        burst    <= '0;
                        rr_wr    <= ~rr_wr;
                    end else if (pkt_due) begin
                        // Retarget FIFOADDR one idle cycle early so it is stable ahead of PKTEND.
                        if (FIFOADDR == FA_OUT) begin
                            state  <= S_PKT;
                            PKTEND <= 1'b0;
                        end else begin
                            FIFOADDR <= FA_OUT;
                        end
                    end
                end
                S_RD_SETUP: begin
                    state <= S_RD_STROBE;
                    SLRD  <= 1'b0;
                end
                S_RD_STROBE: begin
                    state <= S_RD_HOLD1;
                    burst <= burst + 8'd1;
                end
                S_RD_HOLD1: state <= S_RD_HOLD2;
                S_RD_HOLD2: begin
                    if (EMPTY_FLAG && rb_free && (burst < BURST_MAX)) begin
                        state <= S_RD_STROBE;
                        SLRD  <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        SLOE  <= 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    state    <= S_WR_STROBE;
                    SLWR     <= 1'b0;
                    fd_q     <= to_host.data;
                    fd_oe    <= 1'b1;
                    th_ready <= 1'b1;
                end
                S_WR_STROBE: begin
                    state <= S_WR_GAP;
                    burst <= burst + 8'd1;
                end
                S_WR_GAP: begin
                    if (wr_ok && (burst < BURST_MAX)) begin
                        state    <= S_WR_STROBE;
                        SLWR     <= 1'b0;
                        fd_q     <= to_host.data;
                        th_ready <= 1'b1;
                    end else begin
                        state <= S_WR_REL;
                        fd_oe <= 1'b0;
                    end
                end
                S_WR_REL: state <= S_IDLE;
                S_PKT:    state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fx2_slave_fifo_ctrl.sv
// Directed plus randomized bench for fx2_slave_fifo_ctrl with an FX2 endpoint model, a stream
// scoreboard and pin-level protocol checks.
module tb_fx2_slave_fifo_ctrl;
    localparam int unsigned MAXB = 16;
    localparam int unsigned TMO  = 64;
    localparam logic [1:0]  FA_OUT = 2'd0;
    localparam logic [1:0]  FA_IN  = 2'd2;

    logic        ifclk = 1'b0;
    logic        reset = 1'b1;
    wire  [15:0] fd;
    logic        SLWR, SLRD, SLOE, PKTEND;
    logic [1:0]  FIFOADDR;
    logic        EMPTY_FLAG = 1'b0;
    logic        FULL_FLAG  = 1'b1;

    fx2_slave_fifo_ctrl_if #(.WIDTH(16)) fh ();
    fx2_slave_fifo_ctrl_if #(.WIDTH(16)) th ();

    fx2_slave_fifo_ctrl #(
        .OUTEP(2), .INEP(6), .MAX_BURST(MAXB), .PKTEND_TIMEOUT(TMO)
    ) dut (
        .ifclk(ifclk), .reset(reset), .fd(fd),
        .SLWR(SLWR), .SLRD(SLRD), .SLOE(SLOE), .PKTEND(PKTEND), .FIFOADDR(FIFOADDR),
        .EMPTY_FLAG(EMPTY_FLAG), .FULL_FLAG(FULL_FLAG),
        .from_host(fh), .to_host(th)
    );

    always #5 ifclk = ~ifclk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FX2 side: INEP contents as an array, EMPTY_FLAG one cycle behind the pops.
    logic [15:0] host_mem [0:1023];
    int          host_wr = 0;
    int          host_rd = 0;
    logic        s_slrd = 1'b1;
    int          cyc = 0;
    logic [15:0] exp_rd[$];
    logic [15:0] exp_wr[$];
    logic [15:0] src_q[$];
    int          pkt_q[$];

    assign fd = !SLOE ? host_mem[host_rd[9:0]] : 'z;

    always @(posedge ifclk) begin
        cyc        <= cyc + 1;
        EMPTY_FLAG <= (host_wr != host_rd);
        if (!s_slrd && host_rd != host_wr)
            host_rd <= host_rd + 1;
    end

    logic       prev_slrd = 1'b1;
    logic       prev_slwr = 1'b1;
    logic [1:0] prev_addr = FA_IN;
    logic [1:0] slwr_hist = 2'b11;
    int         rd_strobes = 0, wr_strobes = 0;
    int         last_rd_cyc = -100, last_wr_cyc = -100;
    int         run_len = 0;
    logic       run_wr = 1'b0;
    int         bursts[$];
    logic       burst_kind[$];

    function automatic void close_run();
        if (run_len > 0) begin
            bursts.push_back(run_len);
            burst_kind.push_back(run_wr);
        end
        run_len = 0;
    endfunction

    always @(negedge ifclk) begin
        s_slrd = SLRD;
        if (!reset) begin
            if (!SLRD) begin
                check("rd_addr", 32'(FIFOADDR), 32'(FA_IN));
                check("rd_addr_pre", 32'(prev_addr), 32'(FA_IN));
                check("rd_width", 32'(prev_slrd), 32'd1);
                check("rd_oe", 32'(SLOE), 32'd0);
                check("rd_not_empty", 32'(host_rd != host_wr), 32'd1);
                if (run_len > 0 && !run_wr && cyc - last_rd_cyc == 3) run_len++;
                else begin close_run(); run_wr = 1'b0; run_len = 1; end
                check("rd_burst_max", 32'(run_len <= int'(MAXB)), 32'd1);
                last_rd_cyc = cyc;
                rd_strobes++;
            end
            if (!SLWR) begin
                check("wr_addr", 32'(FIFOADDR), 32'(FA_OUT));
                check("wr_addr_pre", 32'(prev_addr), 32'(FA_OUT));
                check("wr_width", 32'(prev_slwr), 32'd1);
                check("wr_oe_off", 32'(SLOE), 32'd1);
                check("wr_pending", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) check("wr_data", 32'(fd), 32'(exp_wr.pop_front()));
                if (run_len > 0 && run_wr && cyc - last_wr_cyc == 2) run_len++;
                else begin close_run(); run_wr = 1'b1; run_len = 1; end
                check("wr_burst_max", 32'(run_len <= int'(MAXB)), 32'd1);
                last_wr_cyc = cyc;
                wr_strobes++;
            end
            if (!PKTEND) begin
                check("pkt_addr", 32'(FIFOADDR), 32'(FA_OUT));
                check("pkt_addr_pre", 32'(prev_addr), 32'(FA_OUT));
                check("pkt_slwr", 32'(SLWR), 32'd1);
                pkt_q.push_back(cyc);
            end
            if (!SLOE) check("bus_turnaround", 32'({slwr_hist, SLWR}), 32'd7);
        end
        prev_slrd = SLRD;
        prev_slwr = SLWR;
        prev_addr = FIFOADDR;
        slwr_hist = {slwr_hist[0], SLWR};
    end

    int rdy_mode = 1;

    task automatic consumer();
        forever begin
            @(negedge ifclk);
            if (!reset && fh.valid && fh.ready) begin
                check("rd_pending", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) check("rd_data", 32'(fh.data), 32'(exp_rd.pop_front()));
            end
            @(posedge ifclk);
            #1;
            fh.ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic producer();
        logic hs;
        forever begin
            @(negedge ifclk);
            hs = th.valid && th.ready;
            @(posedge ifclk);
            #1;
            if (hs) void'(src_q.pop_front());
            th.valid = (src_q.size() != 0);
            th.data  = (src_q.size() != 0) ? src_q[0] : 16'h0000;
        end
    endtask

    task automatic host_push(input logic [15:0] w);
        host_mem[host_wr[9:0]] = w;
        host_wr++;
        exp_rd.push_back(w);
    endtask

    task automatic src_push(input logic [15:0] w);
        src_q.push_back(w);
        exp_wr.push_back(w);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !(exp_rd.size() == 0 && src_q.size() == 0 && exp_wr.size() == 0
                               && host_rd == host_wr)) begin
            @(negedge ifclk);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, p0, d, same, nr, nw;
        logic [15:0] w;
        fh.ready = 1'b0;
        th.valid = 1'b0;
        th.data  = 16'h0000;
        fork
            consumer();
            producer();
        join_none

        repeat (3) @(posedge ifclk);
        @(negedge ifclk);
        check("rst_slrd", 32'(SLRD), 32'd1);
        check("rst_slwr", 32'(SLWR), 32'd1);
        check("rst_sloe", 32'(SLOE), 32'd1);
        check("rst_pktend", 32'(PKTEND), 32'd1);
        check("rst_fifoaddr", 32'(FIFOADDR), 32'(FA_IN));
        check("rst_fh_valid", 32'(fh.valid), 32'd0);
        check("rst_th_ready", 32'(th.ready), 32'd0);
        reset = 1'b0;

        // Three words, one burst with strobes exactly 3 cycles apart
        r0 = rd_strobes;
        host_push(16'h1111); host_push(16'h2222); host_push(16'h3333);
        wait_idle("t1_done", 200);
        @(posedge ifclk); #1; close_run();
        check("t1_reads", 32'(rd_strobes - r0), 32'd3);
        check("t1_nbursts", 32'(bursts.size()), 32'd1);
        check("t1_len", 32'(bursts.size() > 0 ? bursts[0] : 0), 32'd3);
        bursts.delete(); burst_kind.delete();

        // 40 words split into 16,16,8
        for (int i = 0; i < 40; i++) host_push(16'($urandom));
        wait_idle("t2_done", 1000);
        @(posedge ifclk); #1; close_run();
        check("t2_nbursts", 32'(bursts.size()), 32'd3);
        check("t2_b0", 32'(bursts.size() > 0 ? bursts[0] : 0), 32'd16);
        check("t2_b1", 32'(bursts.size() > 1 ? bursts[1] : 0), 32'd16);
        check("t2_b2", 32'(bursts.size() > 2 ? bursts[2] : 0), 32'd8);
        check("t2_no_pkt", 32'(pkt_q.size()), 32'd0);
        bursts.delete(); burst_kind.delete();

        // Consumer stalled: buffer fills with exactly two reads
        @(negedge ifclk);
        rdy_mode = 0;
        repeat (2) @(negedge ifclk);
        r0 = rd_strobes;
        for (int i = 0; i < 6; i++) host_push(16'($urandom));
        repeat (40) @(negedge ifclk);
        check("t5_two_reads", 32'(rd_strobes - r0), 32'd2);
        check("t5_valid", 32'(fh.valid), 32'd1);
        check("t5_head", 32'(fh.data), 32'(exp_rd[0]));
        rdy_mode = 1;
        wait_idle("t5_done", 400);

        // Single write then short-packet commit after the idle timeout
        w0 = wr_strobes; p0 = pkt_q.size();
        src_push(16'hA5A5);
        wait_idle("t3_done", 100);
        repeat (90) @(negedge ifclk);
        check("t3_writes", 32'(wr_strobes - w0), 32'd1);
        check("t3_pkts", 32'(pkt_q.size() - p0), 32'd1);
        d = (pkt_q.size() > p0) ? pkt_q[p0] - last_wr_cyc : -1;
        check("t3_pkt_delay", 32'(d >= int'(TMO) && d <= int'(TMO) + 4), 32'd1);

        // OUTEP full blocks writes until it drains
        FULL_FLAG = 1'b0;
        w0 = wr_strobes;
        for (int i = 0; i < 5; i++) src_push(16'($urandom));
        repeat (30) @(negedge ifclk);
        check("full_blocks", 32'(wr_strobes - w0), 32'd0);
        FULL_FLAG = 1'b1;
        wait_idle("full_done", 200);
        check("full_writes", 32'(wr_strobes - w0), 32'd5);
        repeat (90) @(negedge ifclk);

        // Both directions loaded: bursts alternate
        @(posedge ifclk); #1; close_run();
        bursts.delete(); burst_kind.delete();
        @(negedge ifclk);
        for (int i = 0; i < 64; i++) begin
            host_push(16'($urandom));
            src_push(16'($urandom));
        end
        wait_idle("t4_done", 3000);
        @(posedge ifclk); #1; close_run();
        same = 0; nr = 0; nw = 0;
        for (int i = 0; i < burst_kind.size(); i++) begin
            if (burst_kind[i]) nw++; else nr++;
            if (i > 0 && burst_kind[i] == burst_kind[i-1]) same++;
        end
        check("t4_rd_bursts", 32'(nr), 32'd4);
        check("t4_wr_bursts", 32'(nw), 32'd4);
        check("t4_alternate", 32'(same), 32'd0);

        // Randomized traffic with a jittery consumer
        @(negedge ifclk);
        rdy_mode = 2;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < int'($urandom_range(1, 30)); i++) host_push(16'($urandom));
            for (int i = 0; i < int'($urandom_range(0, 30)); i++) src_push(16'($urandom));
            repeat ($urandom_range(0, 20)) @(negedge ifclk);
        end
        wait_idle("rand_done", 4000);
        rdy_mode = 0;
        repeat (3) @(negedge ifclk);

        // Reset during RD_HOLD1 discards the buffered word
        for (int i = 0; i < 10; i++) host_push(16'($urandom));
        d = 0;
        while (d < 50 && SLRD) begin
            @(negedge ifclk);
            d++;
        end
        check("t6_strobe_seen", 32'(d < 50), 32'd1);
        @(posedge ifclk); #1;
        check("t6_pre_valid", 32'(fh.valid), 32'd1);
        reset = 1'b1;
        @(posedge ifclk);
        @(negedge ifclk);
        check("t6_slrd", 32'(SLRD), 32'd1);
        check("t6_slwr", 32'(SLWR), 32'd1);
        check("t6_sloe", 32'(SLOE), 32'd1);
        check("t6_pktend", 32'(PKTEND), 32'd1);
        check("t6_valid", 32'(fh.valid), 32'd0);
        check("t6_ready", 32'(th.ready), 32'd0);
        reset = 1'b0;
        exp_rd.delete();
        for (int i = host_rd; i < host_wr; i++) begin
            w = host_mem[i];
            exp_rd.push_back(w);
        end
        rdy_mode = 1;
        wait_idle("t6_drain", 400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
